// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program-counter stage with a small LIFO return-address stack.
// Each cycle it picks the next address: return, call, jump or increment, in that order of priority.
// Calls and returns that the stack cannot honour fall back to a plain increment and raise a one-cycle flag.
module pc_stack_unit #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             jump,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] pc,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int SP_W = $clog2(DEPTH + 1);
    localparam logic [SP_W-1:0] SP_MAX = SP_W'(DEPTH);
    localparam logic [SP_W-1:0] SP_ONE = SP_W'(1);

    logic [SP_W-1:0]  sp;
    logic [WIDTH-1:0] stack [DEPTH];

    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] pop_data;
    logic [WIDTH-1:0] pc_next;
    logic [SP_W-1:0]  sp_next;
    logic [SP_W-1:0]  sp_top;

    logic do_ret;
    logic do_call;
    logic do_jump;
    logic do_pop;
    logic do_push;
    logic reject_ret;
    logic reject_call;

    // Flags are decoded straight from the registered stack pointer.
    assign stack_full  = (sp == SP_MAX);
    assign stack_empty = (sp == '0);

    // Return address is the address after the call; wraps naturally at all-ones.
    assign pc_inc = pc + WIDTH'(1);
    assign sp_top = sp - SP_ONE;

    // Resolve the request priority: ret > call > jump > increment, all gated by stall.
    always_comb begin
        do_ret      = !stall && ret;
        do_call     = !stall && !ret && call;
        do_jump     = !stall && !ret && !call && jump;
        do_pop      = do_ret && !stack_empty;
        reject_ret  = do_ret && stack_empty;
        do_push     = do_call && !stack_full;
        reject_call = do_call && stack_full;
    end

    // Read the top-of-stack entry; only entries below sp are ever selected.
    always_comb begin
        pop_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp_top == SP_W'(i)) begin
                pop_data = stack[i];
            end
        end
    end

    // Next pc and stack pointer; rejected calls/returns behave like an increment.
    always_comb begin
        pc_next = pc_inc;
        sp_next = sp;
        if (stall) begin
            pc_next = pc;
        end else if (do_pop) begin
            pc_next = pop_data;
            sp_next = sp - SP_ONE;
        end else if (do_push) begin
            pc_next = target;
            sp_next = sp + SP_ONE;
        end else if (do_jump) begin
            pc_next = target;
        end
    end

    // Register pc, stack pointer and the one-cycle rejection pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= '0;
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pc        <= pc_next;
            sp        <= sp_next;
            overflow  <= reject_call;
            underflow <= reject_ret;
        end
    end

    // Push the return address into the slot at sp; popped entries are left intact.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else if (do_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sp == SP_W'(i)) begin
                    stack[i] <= pc_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: counting, jump, call/return, stack limits, stall, async reset.
module tb_pc_stack_unit;

    logic       clk;
    logic       reset;
    logic       stall;
    logic       jump;
    logic       call;
    logic       ret;
    logic [3:0] target;
    logic [3:0] pc;
    logic       stack_full;
    logic       stack_empty;
    logic       overflow;
    logic       underflow;

    int errors;
    int checks;

    pc_stack_unit #(.WIDTH(4), .DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .jump        (jump),
        .call        (call),
        .ret         (ret),
        .target      (target),
        .pc          (pc),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        stall = 0; jump = 0; call = 0; ret = 0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        idle();
        target = 4'd0;

        // reset state
        #2;
        chk("rst_pc", pc, 0);
        chk("rst_empty", stack_empty, 1);
        chk("rst_full", stack_full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        @(negedge clk);
        reset = 1'b1;

        // 1: free-running count with wrap
        chk("cnt_pc0", pc, 0);
        for (int i = 1; i < 18; i++) begin
            step();
            chk("cnt_pc", pc, i % 16);
        end

        // 2: jump at pc=3
        step(); step();
        chk("jmp_pre", pc, 3);
        jump = 1; target = 4'd9;
        step();
        chk("jmp_pc", pc, 9);
        chk("jmp_empty", stack_empty, 1);
        idle();
        step();
        chk("jmp_inc", pc, 10);

        // 3: call at pc=5 and return
        for (int i = 0; i < 11; i++) step();
        chk("call_pre", pc, 5);
        call = 1; target = 4'd12;
        step();
        chk("call_pc", pc, 12);
        chk("call_empty", stack_empty, 0);
        idle();
        step(); step();
        chk("call_run", pc, 14);
        ret = 1;
        step();
        chk("ret_pc", pc, 6);
        chk("ret_empty", stack_empty, 1);
        idle();

        // 4: fill to DEPTH, overflow, drain, underflow (pc starts at 6)
        call = 1; target = 4'd2;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("fill_pc", pc, 2);
            chk("fill_full", stack_full, (i == 4) ? 1 : 0);
            chk("fill_ovf", overflow, 0);
        end
        step();
        chk("ovf_pc", pc, 3);
        chk("ovf_flag", overflow, 1);
        chk("ovf_full", stack_full, 1);
        idle();
        step();
        chk("ovf_clear", overflow, 0);
        chk("ovf_inc", pc, 4);
        ret = 1;
        step(); chk("pop1", pc, 3); chk("pop1_full", stack_full, 0);
        step(); chk("pop2", pc, 3);
        step(); chk("pop3", pc, 3);
        step(); chk("pop4", pc, 7); chk("pop4_empty", stack_empty, 1);
        chk("pop4_unf", underflow, 0);
        step();
        chk("unf_flag", underflow, 1);
        chk("unf_pc", pc, 8);
        idle();
        step();
        chk("unf_clear", underflow, 0);
        chk("unf_inc", pc, 9);

        // 5: stall overrides everything, then ret beats call on empty stack
        stall = 1; call = 1; jump = 1; ret = 1; target = 4'd7;
        step();
        chk("stall_pc", pc, 9);
        chk("stall_empty", stack_empty, 1);
        chk("stall_full", stack_full, 0);
        chk("stall_ovf", overflow, 0);
        chk("stall_unf", underflow, 0);
        stall = 0; jump = 0;
        step();
        chk("prio_unf", underflow, 1);
        chk("prio_pc", pc, 10);
        chk("prio_empty", stack_empty, 1);
        idle();
        step();
        chk("prio_inc", pc, 11);

        // stall with a non-empty stack keeps the entry
        call = 1; target = 4'd4;
        step();
        chk("scall_pc", pc, 4);
        call = 0; stall = 1; ret = 1;
        step(); step();
        chk("sret_pc", pc, 4);
        chk("sret_empty", stack_empty, 0);
        chk("sret_unf", underflow, 0);
        stall = 0;
        step();
        chk("sret_pop", pc, 12);
        chk("sret_after", stack_empty, 1);
        idle();

        // 6: async reset mid-sequence
        call = 1; target = 4'd1;
        step(); step();
        chk("pre_rst_pc", pc, 1);
        idle();
        #2 reset = 1'b0;
        #1;
        chk("arst_pc", pc, 0);
        chk("arst_empty", stack_empty, 1);
        chk("arst_full", stack_full, 0);
        @(negedge clk);
        reset = 1'b1;
        chk("post_pc0", pc, 0);
        step(); chk("post_pc1", pc, 1);
        step(); chk("post_pc2", pc, 2);
        ret = 1;
        step();
        chk("post_unf", underflow, 1);
        chk("post_unf_pc", pc, 3);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
